// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter for ALU, LSU and debug writebacks
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            dbg_valid,
    input  logic [AW-1:0]   dbg_rd,
    input  logic [XLEN-1:0] dbg_data,
    output logic            dbg_ready,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd_addr,
    output logic [XLEN-1:0] rf_rd_din,
    output logic [1:0]      wb_src
);

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_ALU  = 2'd1;
    localparam logic [1:0] SRC_LSU  = 2'd2;
    localparam logic [1:0] SRC_DBG  = 2'd3;

    // Set when the LSU won the most recent ALU/LSU grant; the ALU then wins the next conflict.
    logic            last_lsu;
    logic            grant_any;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [1:0]      sel_src;

    always_comb begin
        dbg_ready = 1'b0;
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (rst && !hold) begin
            if (dbg_valid) begin
                dbg_ready = 1'b1;
            end else if (alu_valid && lsu_valid) begin
                alu_ready = last_lsu;
                lsu_ready = !last_lsu;
            end else begin
                alu_ready = alu_valid;
                lsu_ready = lsu_valid;
            end
        end
    end

    always_comb begin
        grant_any = dbg_ready | alu_ready | lsu_ready;
        sel_rd    = '0;
        sel_data  = '0;
        sel_src   = SRC_NONE;
        if (dbg_ready) begin
            sel_rd   = dbg_rd;
            sel_data = dbg_data;
            sel_src  = SRC_DBG;
        end else if (alu_ready) begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
            sel_src  = SRC_ALU;
        end else if (lsu_ready) begin
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
            sel_src  = SRC_LSU;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_lsu   <= 1'b1;
            rf_we      <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_din  <= '0;
            wb_src     <= SRC_NONE;
        end else begin
            if (alu_ready) begin
                last_lsu <= 1'b0;
            end else if (lsu_ready) begin
                last_lsu <= 1'b1;
            end
            // Writes to x0 complete the handshake but never reach the register file.
            if (grant_any && sel_rd != '0) begin
                rf_we      <= 1'b1;
                rf_rd_addr <= sel_rd;
                rf_rd_din  <= sel_data;
                wb_src     <= sel_src;
            end else begin
                rf_we  <= 1'b0;
                wb_src <= SRC_NONE;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            hold = 1'b0;
    logic            dbg_valid = 1'b0, alu_valid = 1'b0, lsu_valid = 1'b0;
    logic [AW-1:0]   dbg_rd = '0, alu_rd = '0, lsu_rd = '0;
    logic [XLEN-1:0] dbg_data = '0, alu_data = '0, lsu_data = '0;
    logic            dbg_ready, alu_ready, lsu_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_rd_addr;
    logic [XLEN-1:0] rf_rd_din;
    logic [1:0]      wb_src;

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_din(rf_rd_din), .wb_src(wb_src)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: who was served last among ALU/LSU, plus the visible write port.
    string           m_last = "lsu";
    logic            m_we = 1'b0;
    logic [1:0]      m_src = 2'd0;
    logic [AW-1:0]   m_addr = '0;
    logic [XLEN-1:0] m_din = '0;

    logic [2:0]                exp_rdy, obs_rdy;
    logic [2+1+AW+XLEN-1:0]    exp_out, obs_out;

    function automatic logic [2:0] model_winner();
        int n;
        if (!rst || hold) return 3'b000;
        if (dbg_valid) return 3'b100;
        n = int'(alu_valid) + int'(lsu_valid);
        if (n == 2) return (m_last == "lsu") ? 3'b010 : 3'b001;
        return {1'b0, alu_valid, lsu_valid};
    endfunction

    task automatic model_reset();
        m_last = "lsu";
        m_we = 1'b0; m_src = 2'd0; m_addr = '0; m_din = '0;
    endtask

    task automatic model_commit(input logic [2:0] win);
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] d;
        logic [1:0]      s;
        rd = '0; d = '0; s = 2'd0;
        if (win[2]) begin rd = dbg_rd; d = dbg_data; s = 2'd3; end
        if (win[1]) begin rd = alu_rd; d = alu_data; s = 2'd1; m_last = "alu"; end
        if (win[0]) begin rd = lsu_rd; d = lsu_data; s = 2'd2; m_last = "lsu"; end
        if (win != 3'b000 && rd != 0) begin
            m_we = 1'b1; m_addr = rd; m_din = d; m_src = s;
        end else begin
            m_we = 1'b0; m_src = 2'd0;
        end
    endtask

    // Inputs are set just after a falling edge; readies are sampled 1ns later, outputs 1ns after the rising edge.
    task automatic run_cycle();
        #1;
        obs_rdy = {dbg_ready, alu_ready, lsu_ready};
        exp_rdy = model_winner();
        @(posedge clk);
        model_commit(exp_rdy);
        #1;
        obs_out = {wb_src, rf_we, rf_rd_addr, rf_rd_din};
        exp_out = {m_src, m_we, m_addr, m_din};
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        hold = 0; dbg_valid = 0; alu_valid = 0; lsu_valid = 0;
        dbg_rd = '0; alu_rd = '0; lsu_rd = '0;
        dbg_data = '0; alu_data = '0; lsu_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 0;
        model_reset();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        do_reset();
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h1234_5678;
        run_cycle();
        total_cnt++;
        if (rf_we !== 1'b1) $display("FAIL reset_precondition rf_we got %b exp 1", rf_we);
        else pass_cnt++;
        lsu_valid = 1; dbg_valid = 1;
        #2 rst = 0;
        #1;
        total_cnt++;
        if ({wb_src, rf_we, rf_rd_addr, rf_rd_din} !== '0)
            $display("FAIL reset_outputs got src=%0d we=%b addr=%0d din=%h exp all 0", wb_src, rf_we, rf_rd_addr, rf_rd_din);
        else pass_cnt++;
        total_cnt++;
        if ({dbg_ready, alu_ready, lsu_ready} !== 3'b000)
            $display("FAIL reset_ready got %b exp 000", {dbg_ready, alu_ready, lsu_ready});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({dbg_ready, alu_ready, lsu_ready, rf_we} !== 4'b0000)
            $display("FAIL reset_held got rdy=%b we=%b exp 000/0", {dbg_ready, alu_ready, lsu_ready}, rf_we);
        else pass_cnt++;
        model_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1;
    endtask

    task automatic test_single_alu();
        do_reset();
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        run_cycle();
        total_cnt++;
        if (obs_rdy !== 3'b010) $display("FAIL single_alu ready got %b exp 010", obs_rdy);
        else pass_cnt++;
        total_cnt++;
        if (obs_out !== {2'd1, 1'b1, 5'd5, 32'hDEAD_BEEF})
            $display("FAIL single_alu out got %h exp %h", obs_out, {2'd1, 1'b1, 5'd5, 32'hDEAD_BEEF});
        else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_conflict();
        logic [1:0] seen [3];
        do_reset();
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'h22;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            seen[i] = obs_out[XLEN+AW+2:XLEN+AW+1];
            total_cnt++;
            if (obs_rdy !== exp_rdy) $display("FAIL conflict_ready[%0d] got %b exp %b", i, obs_rdy, exp_rdy);
            else pass_cnt++;
            total_cnt++;
            if (obs_out !== exp_out) $display("FAIL conflict_out[%0d] got %h exp %h", i, obs_out, exp_out);
            else pass_cnt++;
            if (exp_rdy[1]) alu_valid = 0;
            if (exp_rdy[0]) lsu_valid = 0;
            if (i == 1) begin
                alu_valid = 1; alu_rd = 5'd6; alu_data = 32'h66;
                lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h77;
            end
        end
        total_cnt++;
        if ({seen[0], seen[1], seen[2]} !== {2'd1, 2'd2, 2'd1})
            $display("FAIL conflict_order got %0d,%0d,%0d exp 1,2,1", seen[0], seen[1], seen[2]);
        else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_debug();
        logic [1:0] seen [3];
        do_reset();
        dbg_valid = 1; dbg_rd = 5'd9; dbg_data = 32'hA5A5_A5A5;
        alu_valid = 1; alu_rd = 5'd10; alu_data = 32'h1010;
        lsu_valid = 1; lsu_rd = 5'd11; lsu_data = 32'h1111;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            seen[i] = wb_src;
            total_cnt++;
            if (obs_out !== exp_out) $display("FAIL debug_out[%0d] got %h exp %h", i, obs_out, exp_out);
            else pass_cnt++;
            if (exp_rdy[2]) dbg_valid = 0;
            if (exp_rdy[1]) alu_valid = 0;
            if (exp_rdy[0]) lsu_valid = 0;
        end
        total_cnt++;
        if ({seen[0], seen[1], seen[2]} !== {2'd3, 2'd1, 2'd2})
            $display("FAIL debug_order got %0d,%0d,%0d exp 3,1,2", seen[0], seen[1], seen[2]);
        else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_x0();
        do_reset();
        alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h2222;
        run_cycle();
        clear_inputs();
        lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
        run_cycle();
        total_cnt++;
        if (obs_rdy !== 3'b001) $display("FAIL x0_ready got %b exp 001", obs_rdy);
        else pass_cnt++;
        total_cnt++;
        if (obs_out !== {2'd0, 1'b0, 5'd2, 32'h2222})
            $display("FAIL x0_out got %h exp %h", obs_out, {2'd0, 1'b0, 5'd2, 32'h2222});
        else pass_cnt++;
        alu_valid = 1; alu_rd = 5'd12; alu_data = 32'hC;
        lsu_valid = 1; lsu_rd = 5'd13; lsu_data = 32'hD;
        run_cycle();
        total_cnt++;
        if (obs_rdy !== 3'b010) $display("FAIL x0_next_conflict got %b exp 010", obs_rdy);
        else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_hold();
        do_reset();
        alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hA1;
        run_cycle();
        lsu_valid = 1; lsu_rd = 5'd8; lsu_data = 32'hB8;
        alu_rd = 5'd14; alu_data = 32'hAE;
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            total_cnt++;
            if (obs_rdy !== 3'b000 || obs_out[XLEN+AW] !== 1'b0)
                $display("FAIL hold[%0d] got rdy=%b we=%b exp 000/0", i, obs_rdy, obs_out[XLEN+AW]);
            else pass_cnt++;
        end
        hold = 0;
        run_cycle();
        total_cnt++;
        if (obs_rdy !== 3'b001) $display("FAIL hold_release got %b exp 001", obs_rdy);
        else pass_cnt++;
        total_cnt++;
        if (obs_out !== exp_out) $display("FAIL hold_release_out got %h exp %h", obs_out, exp_out);
        else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            hold = ($urandom_range(0, 9) == 0);
            if (!dbg_valid && $urandom_range(0, 7) == 0) begin
                dbg_valid = 1; dbg_rd = AW'($urandom); dbg_data = $urandom;
            end
            if (!alu_valid && $urandom_range(0, 2) != 0) begin
                alu_valid = 1; alu_rd = AW'($urandom); alu_data = $urandom;
            end
            if (!lsu_valid && $urandom_range(0, 2) != 0) begin
                lsu_valid = 1; lsu_rd = AW'($urandom); lsu_data = $urandom;
            end
            run_cycle();
            total_cnt++;
            if (obs_rdy !== exp_rdy) $display("FAIL random_ready[%0d] got %b exp %b", i, obs_rdy, exp_rdy);
            else pass_cnt++;
            total_cnt++;
            if (obs_out !== exp_out) $display("FAIL random_out[%0d] got %h exp %h", i, obs_out, exp_out);
            else pass_cnt++;
            if (exp_rdy[2]) dbg_valid = 0;
            if (exp_rdy[1]) alu_valid = 0;
            if (exp_rdy[0]) lsu_valid = 0;
        end
        clear_inputs();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_alu();
        test_conflict();
        test_debug();
        test_x0();
        test_hold();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Arbitrates the single register-file write port between three writeback sources: the ALU, the load/store unit and the debug module. Accepts one write per cycle through a valid/ready handshake, registers it, and drives the register file's we/rd_addr/rd_din inputs. Sits between the execute/memory stages and register_file; its outputs connect directly to the register file write port.

Parameters:
XLEN, 32, data width of the write port.
AW, 5, register address width (32 architectural registers).

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-low; clears all state while low.
hold  input  1  write-port freeze (e.g. pipeline flush); when 1, no grants are issued.
dbg_valid  input  1  debug write request.
dbg_rd  input  AW  debug destination register.
dbg_data  input  XLEN  debug write data.
dbg_ready  output  1  debug request accepted this cycle.
alu_valid  input  1  ALU writeback request.
alu_rd  input  AW  ALU destination register.
alu_data  input  XLEN  ALU result.
alu_ready  output  1  ALU request accepted this cycle.
lsu_valid  input  1  load writeback request.
lsu_rd  input  AW  load destination register.
lsu_data  input  XLEN  load data.
lsu_ready  output  1  LSU request accepted this cycle.
rf_we  output  1  register file write enable.
rf_rd_addr  output  AW  register file write address.
rf_rd_din  output  XLEN  register file write data.
wb_src  output  2  source of the current rf_* write: 0 none, 1 ALU, 2 LSU, 3 debug.

Behaviour:
- Reset (rst low, asynchronous): rf_we=0, rf_rd_addr=0, rf_rd_din=0, wb_src=0, round-robin pointer = "LSU last" (ALU wins first conflict). All ready outputs are 0 while rst is low.
- Ready outputs are combinational from the valid inputs, hold and the pointer. At most one ready is high per cycle. A handshake completes when valid and ready are both 1 in the same cycle.
- Priority when hold=0:
  - If dbg_valid=1, debug is granted (fixed highest priority; debug may starve the others by design).
  - Otherwise, if exactly one of alu_valid and lsu_valid is 1, that requester is granted.
  - If both are 1, the requester not granted last is granted (two-way round-robin).
- The pointer updates only on an ALU or LSU grant. A debug grant, an idle cycle or a hold cycle leaves it unchanged.
- hold=1: all ready=0. On the next edge rf_we=0 and wb_src=0. The pointer is unchanged.
- Latency: a handshake in cycle N produces rf_we=1 with the granted rd and data in cycle N+1, registered on the edge ending cycle N. The register file commits on the edge ending N+1.
- No grant in cycle N: rf_we=0 and wb_src=0 in cycle N+1. rf_rd_addr and rf_rd_din hold their previous values.
- x0 suppression: a granted request with rd=0 still completes its handshake and the pointer updates as normal. However, rf_we=0, wb_src=0, and rf_rd_addr/rf_rd_din are unchanged in N+1.
- Throughput: one write per cycle and no internal buffering. A requester whose valid is not granted must hold valid, rd and data stable until ready.
- Reset asserted mid-operation: outputs clear immediately; an in-flight registered write is dropped.

Test Plan:
1. Reset: rf_we=1 active, then drive rst=0 mid-cycle -> rf_we, rf_rd_addr, rf_rd_din and wb_src are 0 immediately; all ready=0 until rst=1.
2. Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 in the same cycle; next cycle rf_we=1, rf_rd_addr=5, rf_rd_din=0xDEADBEEF, wb_src=1.
3. ALU/LSU conflict: both valid and held (alu rd=3 data=0x11, lsu rd=4 data=0x22) -> ALU granted first, then LSU. rf writes 3/0x11 then 4/0x22 on consecutive cycles. With both valid again (rd 6/7), ALU wins, confirming pointer alternation.
4. Debug override: dbg (rd=9, data=0xA5A5A5A5), ALU and LSU all valid after reset -> dbg granted, then ALU, then LSU. wb_src sequence is 3, 1, 2.
5. x0 write: lsu_valid=1, lsu_rd=0, lsu_data=0xFFFFFFFF -> lsu_ready=1; next cycle rf_we=0 and wb_src=0. A subsequent ALU/LSU conflict is granted to the ALU.
6. Hold: hold=1 with ALU and LSU valid for 3 cycles -> no ready, rf_we=0. On release, the grant order matches the pointer state from before hold.
